// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-read-port register file.
//   - default data/address widths
//   - clear-sequencer state enum
//   - rf_zero_or_oob(): true when an address must read as zero and
//     must not be written (hardwired entry 0 or beyond the implemented entries)
package regfile_pkg;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    // Address is passed zero-extended to 32 bits so one helper serves any ADDR_W.
    function automatic logic rf_zero_or_oob(input logic [31:0] addr,
                                            input int          num_regs,
                                            input logic        zero_reg);
        logic hit_s;
        hit_s = (zero_reg && (addr == 32'd0)) || (addr >= 32'(num_regs));
        return hit_s;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port of regfile_mp.
//   clk, rst     : clock, synchronous active-high reset
//   busy_i       : clear sequence running; read is suppressed
//   rd_en_i      : read enable for this port
//   rd_addr_i    : read address
//   entry_i      : array contents at rd_addr_i (0 when out of range)
//   wr_fire_i    : a legal write is being committed this cycle
//   wr_addr_i    : write address
//   wr_data_i    : write data (bypass source)
//   rd_data_o    : registered read data, holds when not reading
//   rd_valid_o   : rd_data_o was updated on the last edge
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] entry_i,
    input  logic              wr_fire_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    logic [DATA_W-1:0] rd_data_d;

    // Read-value priority: forced zero, then same-cycle write bypass, then array.
    always_comb begin
        rd_data_d = entry_i;
        if (rf_zero_or_oob(32'(rd_addr_i), NUM_REGS, (ZERO_REG != 0))) begin
            rd_data_d = '0;
        end else if ((BYPASS != 0) && wr_fire_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
        end else begin
            rd_data_d = entry_i;
        end
    end

    // Output register: data updates only on an accepted read, valid pulses with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else if (busy_i) begin
            rd_valid_o <= 1'b0;
        end else if (rd_en_i) begin
            rd_data_o  <= rd_data_d;
            rd_valid_o <= 1'b1;
        end else begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD registered read ports,
// one write port, hardware clear sequencer.
//   clk, rst  : clock, synchronous active-high reset (starts a clear)
//   clr_req   : request a full clear, honoured only when idle
//   rd_en     : per-port read enable          [NUM_RD]
//   rd_addr   : packed read addresses         [NUM_RD*ADDR_W]
//   rd_data   : packed registered read data   [NUM_RD*DATA_W]
//   rd_valid  : per-port "rd_data updated"    [NUM_RD]
//   wr_en, wr_addr, wr_data : write port
//   busy      : clear in progress, reads and writes ignored
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    rf_state_e         state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_fire_s;

    assign busy = (state_q == CLEAR);

    // A write lands only when idle and aimed at a writable, implemented entry.
    assign wr_fire_s = (state_q == IDLE) && wr_en &&
                       !rf_zero_or_oob(32'(wr_addr), NUM_REGS, (ZERO_REG != 0));

    // Clear sequencer: one entry per cycle, back to IDLE after the last entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= '0;
                    end else begin
                        state_q   <= IDLE;
                        clr_ptr_q <= clr_ptr_q;
                    end
                end
                CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q   <= IDLE;
                        clr_ptr_q <= '0;
                    end else begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= clr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q   <= CLEAR;
                    clr_ptr_q <= '0;
                end
            endcase
        end
    end

    // Storage: no reset term, the reset edge itself leaves contents alone and
    // the clear sequence that follows does the zeroing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_fire_s) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] entry_s;

        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

        // Guard the array index; out-of-range reads are forced to zero downstream anyway.
        always_comb begin
            entry_s = '0;
            if (32'(addr_s) < 32'(NUM_REGS)) begin
                entry_s = mem_q[addr_s];
            end else begin
                entry_s = '0;
            end
        end

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_REGS (NUM_REGS),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .busy_i     (busy),
            .rd_en_i    (rd_en[k]),
            .rd_addr_i  (addr_s),
            .entry_i    (entry_s),
            .wr_fire_i  (wr_fire_s),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .rd_data_o  (rd_data[k*DATA_W +: DATA_W]),
            .rd_valid_o (rd_valid[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two instances share stimulus
//   dut 0: 32 entries, bypass on;  dut 1: 24 entries, bypass off.
// A high-level model pushes expected read data per port; a negedge monitor
// pops on rd_valid and also checks busy every cycle.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic [1:0]  rd_en = 2'b00;
    logic [9:0]  rd_addr = 10'd0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    int tests = 0;
    int fails = 0;
    logic check_en = 1'b0;

    // model state
    int          n_regs [2] = '{32, 24};
    bit          byp_m  [2] = '{1'b1, 1'b0};
    logic [31:0] mem_m  [2][32];
    int          clr_left [2] = '{0, 0};
    logic        exp_busy [2] = '{1'b0, 1'b0};
    logic [31:0] exp_q [4][$];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy_a));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy_b));

    // Reference: clearing is modelled as "N busy cycles, then everything is zero".
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                clr_left[d] = n_regs[d];
            end else if (clr_left[d] > 0) begin
                clr_left[d] = clr_left[d] - 1;
                if (clr_left[d] == 0) begin
                    for (int j = 0; j < 32; j++) mem_m[d][j] = 32'd0;
                end
            end else begin
                bit legal;
                legal = wr_en && (int'(wr_addr) < n_regs[d]) && (wr_addr != 5'd0);
                for (int p = 0; p < 2; p++) begin
                    int a;
                    logic [31:0] v;
                    a = int'(rd_addr[p*5 +: 5]);
                    if (rd_en[p]) begin
                        if (a == 0 || a >= n_regs[d]) v = 32'd0;
                        else if (byp_m[d] && legal && int'(wr_addr) == a) v = wr_data;
                        else v = mem_m[d][a];
                        exp_q[d*2+p].push_back(v);
                    end
                end
                if (legal) mem_m[d][wr_addr] = wr_data;
                if (clr_req) clr_left[d] = n_regs[d];
            end
            exp_busy[d] = (clr_left[d] != 0);
        end
    endtask

    task automatic tick(input logic r, input logic cr, input logic [1:0] re,
                        input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        #1;
        rst = r; clr_req = cr; rd_en = re; rd_addr = {ra1, ra0};
        wr_en = we; wr_addr = wa; wr_data = wd;
        model_step();
        if (r) check_en = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b0, 2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: compare busy every cycle, pop the scoreboard on each rd_valid.
    always @(negedge clk) begin
        logic        b;
        logic [1:0]  v;
        logic [63:0] dt;
        logic [31:0] e;
        if (check_en) begin
            for (int d = 0; d < 2; d++) begin
                b  = (d == 0) ? busy_a : busy_b;
                v  = (d == 0) ? rd_valid_a : rd_valid_b;
                dt = (d == 0) ? rd_data_a : rd_data_b;
                tests++;
                if (b !== exp_busy[d]) begin
                    fails++;
                    $display("FAIL busy dut%0d t=%0t: got %b want %b", d, $time, b, exp_busy[d]);
                end
                for (int p = 0; p < 2; p++) begin
                    if (v[p] === 1'b1) begin
                        tests++;
                        if (exp_q[d*2+p].size() == 0) begin
                            fails++;
                            $display("FAIL rd_valid dut%0d port%0d t=%0t: got 1 want 0", d, p, $time);
                        end else begin
                            e = exp_q[d*2+p].pop_front();
                            if (dt[p*32 +: 32] !== e) begin
                                fails++;
                                $display("FAIL rd_data dut%0d port%0d t=%0t: got %h want %h",
                                         d, p, $time, dt[p*32 +: 32], e);
                            end
                        end
                    end else if (v[p] !== 1'b0) begin
                        tests++;
                        fails++;
                        $display("FAIL rd_valid dut%0d port%0d t=%0t: got %b want 0/1", d, p, $time, v[p]);
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) for (int j = 0; j < 32; j++) mem_m[d][j] = 32'd0;

        // 1. reset, clear, read everything
        tick(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        tick(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        #1;
        tests++;
        if (rd_data_a !== 64'd0 || rd_valid_a !== 2'b00) begin
            fails++;
            $display("FAIL reset_out: got data %h valid %b want 0 / 00", rd_data_a, rd_valid_a);
        end
        idle(34);
        read_all();

        // 2. basic write then dual read
        tick(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick(1'b0, 1'b0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);

        // 3. same-cycle write/read of r7, then a follow-up read
        tick(1'b0, 1'b0, 2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'h12345678);
        tick(1'b0, 1'b0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0);

        // 4. zero register and out-of-range writes
        tick(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        tick(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd30, 32'h000000AA);
        tick(1'b0, 1'b0, 2'b11, 5'd0, 5'd30, 1'b0, 5'd0, 32'd0);
        read_all();

        // 5. fill, clear request, traffic during clear
        for (int i = 1; i < 32; i++) tick(1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'(i), 32'(i));
        tick(1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) tick(1'b0, (i == 5), 2'b11, 5'd3, 5'(i), 1'b1, 5'd3, 32'h55);
        idle(2);
        read_all();

        // 6. reset in the middle of a clear
        tick(1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        idle(9);
        tick(1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        idle(34);
        read_all();

        // 7. random traffic, biased toward bypass collisions
        for (int i = 0; i < 600; i++) begin
            logic [4:0] wa, ra0, ra1;
            wa  = 5'($urandom_range(0, 31));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            tick(1'b0, ($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)), ra0, ra1,
                 1'($urandom_range(0, 1)), wa, $urandom);
        end
        idle(34);
        read_all();
        idle(3);
        @(negedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (exp_q[i].size() != 0) begin
                fails++;
                $display("FAIL pending_reads q%0d: got %0d outstanding want 0", i, exp_q[i].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; next generation of the datapath register file in the pipelined MIPS core.
- Adds:
  - configurable width, depth and read-port count
  - registered posedge reads with valid flags
  - optional write-to-read bypass
  - hardware clear sequencer that zeroes the array after reset or on request
- Sits between ID (read) and WB (write); replaces the fixed 2R/1W file.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width in bits.
- NUM_REGS, 32, implemented entries; must satisfy NUM_REGS <= 2**ADDR_W.
- NUM_RD, 2, number of read ports; valid range 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write array contents.
- ZERO_REG, 1, 1 = entry 0 is hardwired to zero.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full array clear; honoured only in IDLE.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_valid  out  NUM_RD  per-port flag: rd_data for that port was updated this cycle.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- busy  out  1  clear sequence in progress; reads and writes are ignored while high.

Behaviour:
- Reset (rst=1 at posedge):
  - rd_data <= 0, rd_valid <= 0.
  - state <= CLEAR, clr_ptr <= 0, busy = 1.
  - Array contents are not touched on the reset edge itself.
- FSM states are IDLE and CLEAR.
  - CLEAR: each cycle writes 0 to entry clr_ptr, then clr_ptr increments.
    - When clr_ptr == NUM_REGS-1, that entry is cleared and state goes to IDLE on the same edge.
    - CLEAR therefore lasts exactly NUM_REGS cycles after rst deasserts.
  - IDLE: clr_req=1 at posedge -> CLEAR with clr_ptr=0.
    - Any wr_en presented on that same cycle is still performed; the clear then overwrites it.
  - rst during CLEAR restarts the sequence with clr_ptr=0.
  - clr_req during CLEAR is ignored; it is not queued.
- busy is combinational: busy = (state==CLEAR).
- Write (IDLE only):
  - At posedge, if wr_en=1, wr_addr < NUM_REGS, and not (ZERO_REG && wr_addr==0), then entry[wr_addr] <= wr_data.
  - Any other write is silently dropped.
- Read (IDLE only), per port k, when rd_en[k]=1 at posedge:
  - rd_data_k <= value computed in this priority order:
    1. 0 if (ZERO_REG && addr==0) or addr >= NUM_REGS.
    2. wr_data if BYPASS && wr_en && wr_addr==addr && the write is legal.
    3. entry[addr] otherwise.
  - rd_valid[k] <= 1.
  - Latency: 1 cycle from address to data.
- rd_en[k]=0: rd_data_k holds its previous value; rd_valid[k] <= 0.
- During CLEAR: all rd_valid <= 0, rd_data holds, writes are dropped.
- BYPASS=0 with a same-address read and write: the read returns the old value; the new value is visible from the next read.
- All read ports are independent. Any number of ports may read the same address in the same cycle.
- No X is ever driven on outputs after the first reset edge.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams for default DATA_W and ADDR_W
  - the FSM state enum {IDLE, CLEAR}
  - function rf_zero_or_oob(addr) for the zero/out-of-range check
- One natural sub-module: regfile_rd_port (one per read port, generate loop).
  - Contains the bypass mux and the output register for that port.
  - Parameters: DATA_W, ADDR_W, NUM_REGS, BYPASS, ZERO_REG.
- Array, write logic and clear FSM stay in the top module.

Test Plan:
1. Clear after reset:
   - Stimulus: rst high 2 cycles, then low.
   - Required: busy high for exactly 32 cycles after deassert, then low. Reading all 32 addresses then returns 0 with rd_valid=1.
2. Basic write/read:
   - Stimulus: write 0xDEADBEEF to r5; next cycle read r5 on port 0 and r5 on port 1.
   - Required: both ports show 0xDEADBEEF with rd_valid=2'b11 one cycle after the read is presented.
3. Bypass, BYPASS=1:
   - Stimulus: same cycle wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr0=7.
   - Required: port 0 returns 0x12345678 next cycle.
   - Repeat with BYPASS=0: port 0 returns the old value 0, and a following read returns 0x12345678.
4. Zero register and out-of-range:
   - Stimulus: write 0xFFFFFFFF to r0. With NUM_REGS=24, write 0xAA to addr 30.
   - Required: reads of r0 and addr 30 both return 0. No other entry changes.
5. Clear request mid-operation:
   - Stimulus: fill r1..r31 with r[i]=i; pulse clr_req. During CLEAR assert wr_en to r3 with 0x55 and rd_en on all ports.
   - Required: busy high 32 cycles, rd_valid stays 0, and afterwards every register reads 0 (the r3 write is dropped).
6. Reset mid-clear:
   - Stimulus: assert rst at cycle 10 of CLEAR.
   - Required: busy remains high for 32 more cycles after rst deasserts, with clr_ptr restarting from 0.
